ram_port_arbiter: RTL and testbench

Arbitrates the core instruction-fetch port and the data bus device port onto one single-port RAM, so the system RAM can be built from a single-port macro instead of a dual-port one. Sits between the core/bus and the RAM; one access per cycle, fixed one-cycle read latency, with responses routed back to the requester that was granted. Data accesses win by default; an optional starvation guard forces an instruction grant after a bounded wait.

---
 rtl/ram_port_arbiter_if.sv | 47 ++++
 rtl/ram_port_arbiter.sv | 93 +++++++++
 tb/tb_ram_port_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the instruction port, data port and single-port RAM port around ram_port_arbiter.
// Signal suffixes are from the arbiter's point of view (slave modport).
interface ram_port_arbiter_if #(
   parameter int unsigned AddrWidth = 14
) ();

   logic                 instr_req_i;
   logic [31:0]          instr_addr_i;
   logic                 instr_gnt_o;
   logic                 instr_rvalid_o;
   logic [31:0]          instr_rdata_o;

   logic                 data_req_i;
   logic                 data_we_i;
   logic [3:0]           data_be_i;
   logic [31:0]          data_addr_i;
   logic [31:0]          data_wdata_i;
   logic                 data_gnt_o;
   logic                 data_rvalid_o;
   logic [31:0]          data_rdata_o;

   logic                 mem_req_o;
   logic                 mem_we_o;
   logic [3:0]           mem_be_o;
   logic [AddrWidth-1:0] mem_addr_o;
   logic [31:0]          mem_wdata_o;
   logic [31:0]          mem_rdata_i;

   modport slave (
      input  instr_req_i, instr_addr_i,
      output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
      input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      output data_gnt_o, data_rvalid_o, data_rdata_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i
   );

   modport master (
      output instr_req_i, instr_addr_i,
      input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
      output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      input  data_gnt_o, data_rvalid_o, data_rdata_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i
   );

endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and the data bus; data has priority.
// Define ARB_STARVE_GUARD_EN to force an instruction grant after MaxWait lost cycles.
module ram_port_arbiter #(
   parameter int unsigned AddrWidth = 14,
   parameter int unsigned MaxWait   = 4
) (
   input logic               clk_i,
   input logic               rst_i,
   ram_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {RspIdle, RspInstr, RspData} rsp_e;

   rsp_e rsp_q, rsp_d;
   logic force_instr;
   logic sel_data, sel_instr;
   logic gnt_data, gnt_instr;
   logic instr_rvalid, data_rvalid;

`ifdef ARB_STARVE_GUARD_EN
   logic [3:0] wait_q, wait_d;

   always_comb begin
      wait_d = wait_q;
      if (!bus.instr_req_i || gnt_instr) begin
         wait_d = 4'd0;
      end else if (wait_q != 4'hF) begin
         wait_d = wait_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wait_q <= 4'd0;
      end else begin
         wait_q <= wait_d;
      end
   end

   assign force_instr = bus.instr_req_i & (wait_q == 4'(MaxWait));
`else
   logic unused_max_wait;
   assign unused_max_wait = ^4'(MaxWait);
   assign force_instr     = 1'b0;
`endif

   // Steering follows the inputs even in reset; only the strobes and grants are gated.
   assign sel_data  = bus.data_req_i & ~force_instr;
   assign sel_instr = bus.instr_req_i & ~sel_data;
   assign gnt_data  = sel_data & ~rst_i;
   assign gnt_instr = sel_instr & ~rst_i;

   assign bus.data_gnt_o  = gnt_data;
   assign bus.instr_gnt_o = gnt_instr;

   assign bus.mem_req_o   = gnt_data | gnt_instr;
   assign bus.mem_we_o    = sel_data & bus.data_we_i;
   assign bus.mem_be_o    = sel_data ? bus.data_be_i : 4'b0000;
   assign bus.mem_wdata_o = sel_data ? bus.data_wdata_i : 32'd0;
   assign bus.mem_addr_o  = sel_data  ? bus.data_addr_i[AddrWidth+1:2]  :
                            sel_instr ? bus.instr_addr_i[AddrWidth+1:2] : '0;

   always_comb begin
      rsp_d = RspIdle;
      if (gnt_data) begin
         rsp_d = RspData;
      end else if (gnt_instr) begin
         rsp_d = RspInstr;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_q <= RspIdle;
      end else begin
         rsp_q <= rsp_d;
      end
   end

   // A response still in flight when reset arrives is dropped, not delivered.
   assign instr_rvalid = (rsp_q == RspInstr) & ~rst_i;
   assign data_rvalid  = (rsp_q == RspData) & ~rst_i;

   assign bus.instr_rvalid_o = instr_rvalid;
   assign bus.data_rvalid_o  = data_rvalid;
   assign bus.instr_rdata_o  = instr_rvalid ? bus.mem_rdata_i : 32'd0;
   assign bus.data_rdata_o   = data_rvalid ? bus.mem_rdata_i : 32'd0;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.instr_addr_i[31:AddrWidth+2], bus.instr_addr_i[1:0],
                               bus.data_addr_i[31:AddrWidth+2], bus.data_addr_i[1:0]};

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural one-cycle-latency RAM.
// Expectations for the contention test depend on ARB_STARVE_GUARD_EN.
module tb_ram_port_arbiter;

   localparam int unsigned AW = 14;
   localparam int unsigned Depth = 1 << AW;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit Guard = 1'b1;
`else
   localparam bit Guard = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   ram_port_arbiter_if #(.AddrWidth(AW)) bus ();

   ram_port_arbiter #(
      .AddrWidth(AW),
      .MaxWait  (4)
   ) u_dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: unwritten words read back as 0xA500_0000 | word index.
   bit [31:0] ram [Depth];
   bit        ram_written [Depth];
   logic [31:0] ram_rdata_q;

   function automatic logic [31:0] word_at(input int unsigned a);
      return ram_written[a] ? ram[a] : (32'hA500_0000 | 32'(a));
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = cur;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (bus.mem_req_o) begin
         if (bus.mem_we_o) begin
            ram[bus.mem_addr_o] <= merge(word_at(int'(bus.mem_addr_o)), bus.mem_wdata_o,
                                         bus.mem_be_o);
            ram_written[bus.mem_addr_o] <= 1'b1;
         end else begin
            ram_rdata_q <= word_at(int'(bus.mem_addr_o));
         end
      end
   end

   assign bus.mem_rdata_i = ram_rdata_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   // who: 0 = no response, 1 = instruction, 2 = data
   task automatic check_rsp(input string tag, input int who, input logic [31:0] exp_data);
      check({tag, "_irv"}, 32'(bus.instr_rvalid_o), 32'(who == 1));
      check({tag, "_drv"}, 32'(bus.data_rvalid_o), 32'(who == 2));
      if (who == 1) check({tag, "_irdata"}, bus.instr_rdata_o, exp_data);
      if (who == 2) check({tag, "_drdata"}, bus.data_rdata_o, exp_data);
   endtask

   task automatic idle_inputs();
      bus.instr_req_i  = 1'b0;
      bus.instr_addr_i = 32'd0;
      bus.data_req_i   = 1'b0;
      bus.data_we_i    = 1'b0;
      bus.data_be_i    = 4'h0;
      bus.data_addr_i  = 32'd0;
      bus.data_wdata_i = 32'd0;
   endtask

   initial begin
      int prev;
      logic [31:0] prev_data;
      bit exp_instr;

      n_tests = 0;
      n_fail  = 0;
      idle_inputs();
      rst = 1'b1;
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h0010_0080;
      #1;
      check("rst_igнt_forced", 32'(bus.instr_gnt_o), 32'd0);
      check("rst_memreq_forced", 32'(bus.mem_req_o), 32'd0);
      check("rst_irv", 32'(bus.instr_rvalid_o), 32'd0);
      next_cycle();
      check("rst_after_edge_irv", 32'(bus.instr_rvalid_o), 32'd0);
      check("rst_after_edge_drv", 32'(bus.data_rvalid_o), 32'd0);
      check("rst_irdata", bus.instr_rdata_o, 32'd0);
      check("rst_drdata", bus.data_rdata_o, 32'd0);

      next_cycle();
      rst = 1'b0;
      idle_inputs();
      settle();
      check("idle_memreq", 32'(bus.mem_req_o), 32'd0);
      check("idle_memaddr", 32'(bus.mem_addr_o), 32'd0);
      check_rsp("idle", 0, 32'd0);

      // Single instruction fetch
      next_cycle();
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h0010_0080;
      settle();
      check("if_gnt", 32'(bus.instr_gnt_o), 32'd1);
      check("if_dgnt", 32'(bus.data_gnt_o), 32'd0);
      check("if_memreq", 32'(bus.mem_req_o), 32'd1);
      check("if_memwe", 32'(bus.mem_we_o), 32'd0);
      check("if_memaddr", 32'(bus.mem_addr_o), 32'h020);
      next_cycle();
      idle_inputs();
      settle();
      check_rsp("if_rsp", 1, 32'hA500_0020);

      // Partial write then read back
      next_cycle();
      bus.data_req_i   = 1'b1;
      bus.data_we_i    = 1'b1;
      bus.data_be_i    = 4'b0011;
      bus.data_addr_i  = 32'h0010_0004;
      bus.data_wdata_i = 32'hDEAD_BEEF;
      settle();
      check_rsp("wr_prev", 0, 32'd0);
      check("wr_gnt", 32'(bus.data_gnt_o), 32'd1);
      check("wr_memwe", 32'(bus.mem_we_o), 32'd1);
      check("wr_membe", 32'(bus.mem_be_o), 32'h3);
      check("wr_memaddr", 32'(bus.mem_addr_o), 32'h001);
      check("wr_memwdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
      next_cycle();
      bus.data_we_i    = 1'b0;
      bus.data_be_i    = 4'hF;
      bus.data_wdata_i = 32'd0;
      settle();
      check("wr_rsp_drv", 32'(bus.data_rvalid_o), 32'd1);
      check("rd_gnt", 32'(bus.data_gnt_o), 32'd1);
      check("rd_memwe", 32'(bus.mem_we_o), 32'd0);
      check("rd_memaddr", 32'(bus.mem_addr_o), 32'h001);
      next_cycle();
      idle_inputs();
      settle();
      check_rsp("rd_rsp", 2, 32'hA500_BEEF);

      // Contention: both ports request every cycle for 20 cycles
      prev = 0;
      prev_data = 32'd0;
      for (int k = 0; k < 20; k++) begin
         next_cycle();
         bus.instr_req_i  = 1'b1;
         bus.instr_addr_i = 32'h0010_0080;
         bus.data_req_i   = 1'b1;
         bus.data_we_i    = 1'b0;
         bus.data_be_i    = 4'hF;
         bus.data_addr_i  = 32'h0010_0008;
         settle();
         exp_instr = Guard && ((k % 5) == 4);
         check($sformatf("cont%0d_igнt", k), 32'(bus.instr_gnt_o), 32'(exp_instr));
         check($sformatf("cont%0d_dgnt", k), 32'(bus.data_gnt_o), 32'(!exp_instr));
         check_rsp($sformatf("cont%0d", k), prev, prev_data);
         prev      = exp_instr ? 1 : 2;
         prev_data = exp_instr ? 32'hA500_0020 : 32'hA500_0002;
      end
      next_cycle();
      idle_inputs();
      settle();
      check_rsp("cont_tail", prev, prev_data);

      // Alternating single-port requests, back to back
      prev = 0;
      prev_data = 32'd0;
      for (int k = 0; k < 8; k++) begin
         next_cycle();
         idle_inputs();
         if ((k % 2) == 0) begin
            bus.instr_req_i  = 1'b1;
            bus.instr_addr_i = (32'h100 + 32'(k)) << 2;
         end else begin
            bus.data_req_i  = 1'b1;
            bus.data_be_i   = 4'hF;
            bus.data_addr_i = (32'h200 + 32'(k)) << 2;
         end
         settle();
         check($sformatf("alt%0d_igнt", k), 32'(bus.instr_gnt_o), 32'((k % 2) == 0));
         check($sformatf("alt%0d_dgnt", k), 32'(bus.data_gnt_o), 32'((k % 2) == 1));
         check_rsp($sformatf("alt%0d", k), prev, prev_data);
         prev      = ((k % 2) == 0) ? 1 : 2;
         prev_data = ((k % 2) == 0) ? (32'hA500_0100 + 32'(k)) : (32'hA500_0200 + 32'(k));
      end
      next_cycle();
      idle_inputs();
      settle();
      check_rsp("alt_tail", prev, prev_data);

      // Reset with a data read response in flight
      next_cycle();
      bus.data_req_i  = 1'b1;
      bus.data_be_i   = 4'hF;
      bus.data_addr_i = 32'h0000_000C;
      settle();
      check("rstf_gnt", 32'(bus.data_gnt_o), 32'd1);
      next_cycle();
      idle_inputs();
      rst = 1'b1;
      settle();
      check_rsp("rstf_inrst", 0, 32'd0);
      check("rstf_drdata", bus.data_rdata_o, 32'd0);
      check("rstf_memreq", 32'(bus.mem_req_o), 32'd0);
      next_cycle();
      rst = 1'b0;
      settle();
      check_rsp("rstf_after", 0, 32'd0);
      check("rstf_after_drdata", bus.data_rdata_o, 32'd0);

      // Normal operation resumes after reset
      next_cycle();
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h0000_0080;
      settle();
      check("post_igнt", 32'(bus.instr_gnt_o), 32'd1);
      next_cycle();
      idle_inputs();
      settle();
      check_rsp("post_rsp", 1, 32'hA500_0020);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
